// File: rtl/thee_nrz_pre_emphasis_driver_if.sv
// Word handshake between a data source and the NRZ pre-emphasis driver.
//   data_in    : word to transmit
//   data_valid : data_in valid
//   data_ready : driver can accept a word this cycle
interface thee_nrz_pre_emphasis_driver_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/thee_nrz_pre_emphasis_driver.sv
// NRZ transmit driver with optional de-emphasis of repeated bits.
// Words arrive over a valid/ready handshake into a holding register. They are
// then moved to a shifter and serialized MSB first, each bit for
// CYCLES_PER_BIT cycles, as a real-valued line level.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : data_in / data_valid / data_ready handshake (slave side)
//   tx_out     : driven line level (MID when idle)
//   tx_active  : a bit is being driven this cycle
//   bit_strobe : high on the first cycle of each bit
module thee_nrz_pre_emphasis_driver #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CYCLES_PER_BIT = 4,
  parameter real         VMAX           = 1.0,
  parameter real         VMIN           = -1.0,
  parameter real         DEEMPH         = 0.0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  thee_nrz_pre_emphasis_driver_if.slave         bus,
  output real                                   tx_out,
  output logic                                  tx_active,
  output logic                                  bit_strobe
);

  localparam real         MID     = (VMAX + VMIN) / 2.0;
  localparam real         HALF    = (VMAX - VMIN) / 2.0;
  localparam real         HALF_DE = HALF * (1.0 - DEEMPH);
  localparam int unsigned CW      = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int unsigned BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Reject illegal configurations at elaboration
  if (DEEMPH < 0.0 || DEEMPH >= 1.0) begin : g_bad_deemph
    $fatal(1, "DEEMPH must lie in [0.0, 1.0)");
  end
  if (CYCLES_PER_BIT < 1) begin : g_bad_cpb
    $fatal(1, "CYCLES_PER_BIT must be >= 1");
  end
  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "WIDTH must be >= 2");
  end

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             prev_valid_q, prev_valid_d;
  logic             prev_bit_q, prev_bit_d;
  real              tx_out_q, tx_out_d;
  logic             tx_active_q, tx_active_d;
  logic             bit_strobe_q, bit_strobe_d;

  logic             accept;
  logic             load;
  logic             next_bit;
  logic             go_idle;
  logic             drive_en;
  logic             drive_b;
  logic             last_cyc;
  logic             last_bit;

  assign bus.data_ready = !rst && !hold_full_q;
  assign accept         = bus.data_valid && !hold_full_q;
  assign last_cyc       = (cyc_q == CW'(CYCLES_PER_BIT - 1));
  assign last_bit       = (bit_q == BW'(WIDTH - 1));

  // Next-state, datapath and output level
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    cyc_d        = cyc_q;
    prev_valid_d = prev_valid_q;
    prev_bit_d   = prev_bit_q;
    tx_out_d     = tx_out_q;
    tx_active_d  = tx_active_q;
    bit_strobe_d = 1'b0;
    load         = 1'b0;
    next_bit     = 1'b0;
    go_idle      = 1'b0;
    drive_en     = 1'b0;
    drive_b      = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      SHIFT: begin
        if (last_cyc) begin
          if (!last_bit)        next_bit = 1'b1;
          else if (hold_full_q) load     = 1'b1;
          else                  go_idle  = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (load) begin
      state_d     = SHIFT;
      shift_d     = hold_q;
      bit_d       = '0;
      cyc_d       = '0;
      hold_full_d = 1'b0;
      drive_en    = 1'b1;
      drive_b     = hold_q[WIDTH-1];
    end

    if (next_bit) begin
      shift_d  = shift_q << 1;
      bit_d    = bit_q + BW'(1);
      cyc_d    = '0;
      drive_en = 1'b1;
      drive_b  = shift_q[WIDTH-2];
    end

    if (go_idle) begin
      state_d      = IDLE;
      cyc_d        = '0;
      bit_d        = '0;
      tx_out_d     = MID;
      tx_active_d  = 1'b0;
      prev_valid_d = 1'b0;
    end

    // Repeated bits get the reduced swing; the first bit after idle is a transition
    if (drive_en) begin
      if (prev_valid_q && (drive_b == prev_bit_q))
        tx_out_d = drive_b ? (MID + HALF_DE) : (MID - HALF_DE);
      else
        tx_out_d = drive_b ? (MID + HALF) : (MID - HALF);
      tx_active_d  = 1'b1;
      bit_strobe_d = 1'b1;
      prev_valid_d = 1'b1;
      prev_bit_d   = drive_b;
    end

    // Transfer frees the slot first, then an accept may refill it
    if (accept) begin
      hold_d      = bus.data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      bit_q        <= '0;
      cyc_q        <= '0;
      prev_valid_q <= 1'b0;
      prev_bit_q   <= 1'b0;
      tx_out_q     <= MID;
      tx_active_q  <= 1'b0;
      bit_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      cyc_q        <= cyc_d;
      prev_valid_q <= prev_valid_d;
      prev_bit_q   <= prev_bit_d;
      tx_out_q     <= tx_out_d;
      tx_active_q  <= tx_active_d;
      bit_strobe_q <= bit_strobe_d;
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_active  = tx_active_q;
  assign bit_strobe = bit_strobe_q;

endmodule
